bp_table_scheduler: RTL and testbench

BP_TABLE_SCHEDULER -- requirements
Module: bp_table_scheduler

---
 rtl/bp_table_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_bp_table_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_table_scheduler.sv
// Branch-predictor table port scheduler: shares one single-port counter table
// between prediction lookups and a small FIFO of training updates
// (read-modify-write of signed saturating confidence counters).
module bp_table_scheduler #(
  parameter int ADDR_WIDTH   = 32,
  parameter int IDX_BITS     = 8,
  parameter int ENTRY_W      = 6,
  parameter int DEPTH        = 4,
  parameter int THETA        = 14,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic                  req_stall,
  output logic                  pred_valid,
  output logic                  pred_taken,
  input  logic                  fb_valid,
  input  logic [ADDR_WIDTH-1:0] fb_pc,
  input  logic                  fb_mispredict,
  input  logic                  fb_outcome,
  output logic                  fb_ready,
  output logic                  tbl_en,
  output logic                  tbl_we,
  output logic [IDX_BITS-1:0]   tbl_addr,
  output logic [ENTRY_W-1:0]    tbl_wdata,
  input  logic [ENTRY_W-1:0]    tbl_rdata,
  output logic [15:0]           drop_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int SV_W   = $clog2(STARVE_LIMIT + 1);
  localparam int FIFO_W = IDX_BITS + 2;

  localparam logic [ENTRY_W-1:0] SAT_MAX = {1'b0, {(ENTRY_W-1){1'b1}}};
  localparam logic [ENTRY_W-1:0] SAT_MIN = {1'b1, {(ENTRY_W-1){1'b0}}};
  localparam logic [ENTRY_W:0]   THETA_V = (ENTRY_W+1)'(THETA);
  // The STARVE_LIMIT-th blocked cycle is the one where training is forced.
  localparam logic [SV_W-1:0]    STARVE_HIT = SV_W'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [SV_W-1:0]       starv_q, starv_d;
  logic [ENTRY_W-1:0]    new_q, new_d;
  logic                  pred_valid_q;
  logic [15:0]           drop_q;
  logic [FIFO_W-1:0]     fifo_mem [DEPTH];

  logic [IDX_BITS-1:0]   req_idx, fb_idx, head_idx;
  logic                  head_mis, head_out;
  logic                  push, pop, fifo_empty;
  logic                  train_want, force_train, lookup_go, train_go;
  logic [ENTRY_W:0]      old_ext, old_abs;
  logic [ENTRY_W-1:0]    new_val;
  logic                  skip_write;
  logic                  unused_pc_bits;

  assign req_idx = req_pc[IDX_BITS+1:2];
  assign fb_idx  = fb_pc[IDX_BITS+1:2];
  assign {head_idx, head_mis, head_out} = fifo_mem[rd_ptr_q];
  assign unused_pc_bits = ^{req_pc[ADDR_WIDTH-1:IDX_BITS+2], req_pc[1:0],
                            fb_pc[ADDR_WIDTH-1:IDX_BITS+2], fb_pc[1:0]};

  assign fifo_empty = (count_q == '0);
  assign fb_ready   = (count_q < CNT_W'(DEPTH));
  assign push       = fb_valid && fb_ready;

  // Port arbitration: lookups win unless training has been starved too long.
  // Gated by rst_n so the table port is quiet while reset is held.
  always_comb begin
    train_want  = ((state_q == S_IDLE) && !fifo_empty) || (state_q == S_WR);
    force_train = train_want && (starv_q == STARVE_HIT);
    lookup_go   = rst_n && req_valid && !force_train;
    train_go    = rst_n && train_want && !lookup_go;
  end

  assign req_stall = force_train;

  // Counter arithmetic on the value read back for the head entry.
  always_comb begin
    old_ext = {tbl_rdata[ENTRY_W-1], tbl_rdata};
    old_abs = old_ext[ENTRY_W] ? (~old_ext + 1'b1) : old_ext;
    if (head_out) begin
      new_val = (tbl_rdata == SAT_MAX) ? tbl_rdata : tbl_rdata + ENTRY_W'(1);
    end else begin
      new_val = (tbl_rdata == SAT_MIN) ? tbl_rdata : tbl_rdata - ENTRY_W'(1);
    end
    // Confident and correct: leave the counter alone.
    skip_write = !head_mis && (old_abs > THETA_V);
  end

  // Training FSM next state, pop and update-value capture.
  always_comb begin
    state_d = state_q;
    new_d   = new_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (train_go) state_d = S_RD;
      S_RD: begin
        new_d = new_val;
        if (skip_write) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (train_go) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Starvation counter: counts cycles training wanted the port but lost it.
  always_comb begin
    starv_d = starv_q;
    if (train_go) begin
      starv_d = '0;
    end else if (train_want && lookup_go) begin
      starv_d = starv_q + SV_W'(1);
    end
  end

  // Table port drive.
  always_comb begin
    tbl_en    = lookup_go || train_go;
    tbl_we    = train_go && (state_q == S_WR);
    tbl_addr  = '0;
    tbl_wdata = '0;
    if (lookup_go) begin
      tbl_addr = req_idx;
    end else if (train_go) begin
      tbl_addr = head_idx;
    end
    if (tbl_we) tbl_wdata = new_q;
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_valid_q & ~tbl_rdata[ENTRY_W-1];
  assign drop_count = drop_q;

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starv_q      <= '0;
      new_q        <= '0;
      pred_valid_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      starv_q      <= starv_d;
      new_q        <= new_d;
      pred_valid_q <= lookup_go;
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (fb_valid && !fb_ready && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  // FIFO payload storage; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {fb_idx, fb_mispredict, fb_outcome};
  end

endmodule

// File: tb/tb_bp_table_scheduler.sv
// Directed bench for bp_table_scheduler with a behavioural single-port table.
module tb_bp_table_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_stall;
  logic        pred_valid;
  logic        pred_taken;
  logic        fb_valid;
  logic [31:0] fb_pc;
  logic        fb_mispredict;
  logic        fb_outcome;
  logic        fb_ready;
  logic        tbl_en;
  logic        tbl_we;
  logic [7:0]  tbl_addr;
  logic [5:0]  tbl_wdata;
  logic [5:0]  tbl_rdata;
  logic [15:0] drop_count;

  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [5:0]  pl_data = '0;
  logic [5:0]  mem [256];

  int tests = 0;
  int fails = 0;

  bp_table_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_pc(req_pc), .req_stall(req_stall),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .fb_valid(fb_valid), .fb_pc(fb_pc), .fb_mispredict(fb_mispredict),
    .fb_outcome(fb_outcome), .fb_ready(fb_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Single-port table with one-cycle registered read, plus a bench preload port.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (tbl_en && tbl_we) mem[tbl_addr] <= tbl_wdata;
    if (tbl_en && !tbl_we) tbl_rdata <= mem[tbl_addr];
  end

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic [5:0]  val;
    logic [7:0]  exp_addr;
    logic        exp_taken;
  } look_vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic        outc;
    logic [5:0]  old;
    logic [7:0]  exp_idx;
    logic        exp_write;
    logic [5:0]  exp_val;
  } train_vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [5:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick;
    pl_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    look_vec_t  lv [7];
    train_vec_t tv [9];
    int n;

    lv[0] = '{1'b1, 32'h0000_0040, 6'h3F, 8'h10, 1'b0};
    lv[1] = '{1'b1, 32'h0000_0044, 6'h00, 8'h11, 1'b1};
    lv[2] = '{1'b1, 32'h0000_03FC, 6'h1F, 8'hFF, 1'b1};
    lv[3] = '{1'b1, 32'h0000_0100, 6'h20, 8'h40, 1'b0};
    lv[4] = '{1'b1, 32'h0000_0400, 6'h01, 8'h00, 1'b1};
    lv[5] = '{1'b0, 32'h0000_0048, 6'h00, 8'h12, 1'b0};
    lv[6] = '{1'b1, 32'h0000_02A8, 6'h3E, 8'hAA, 1'b0};

    tv[0] = '{32'h14, 1'b1, 1'b1, 6'h1F, 8'h05, 1'b1, 6'h1F}; // +31 saturates
    tv[1] = '{32'h18, 1'b0, 1'b0, 6'h2C, 8'h06, 1'b0, 6'h00}; // -20 confident
    tv[2] = '{32'h1C, 1'b1, 1'b0, 6'h03, 8'h07, 1'b1, 6'h02};
    tv[3] = '{32'h20, 1'b0, 1'b1, 6'h0E, 8'h08, 1'b1, 6'h0F}; // |14| not above
    tv[4] = '{32'h24, 1'b0, 1'b1, 6'h0F, 8'h09, 1'b0, 6'h00}; // |15| above
    tv[5] = '{32'h28, 1'b0, 1'b1, 6'h32, 8'h0A, 1'b1, 6'h33}; // -14 -> -13
    tv[6] = '{32'h2C, 1'b0, 1'b0, 6'h31, 8'h0B, 1'b0, 6'h00}; // -15 confident
    tv[7] = '{32'h30, 1'b1, 1'b0, 6'h20, 8'h0C, 1'b1, 6'h20}; // -32 saturates
    tv[8] = '{32'h34, 1'b1, 1'b1, 6'h14, 8'h0D, 1'b1, 6'h15};

    rst_n = 1'b0; req_valid = 1'b1; req_pc = 32'h40;
    fb_valid = 1'b0; fb_pc = '0; fb_mispredict = 1'b0; fb_outcome = 1'b0;
    tick; tick;
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_req_stall", req_stall, 0);
    chk("rst_fb_ready", fb_ready, 1);
    chk("rst_tbl_en", tbl_en, 0);
    chk("rst_tbl_we", tbl_we, 0);
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_tbl_wdata", tbl_wdata, 0);
    chk("rst_drop_count", drop_count, 0);
    $display("[TB] reset outputs checked");
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 7; i++) preload(lv[i].exp_addr, lv[i].val);
    for (int i = 0; i < 9; i++) preload(tv[i].exp_idx, tv[i].old);
    preload(8'h20, 6'h00);
    for (int i = 0; i < 5; i++) preload(8'h30 + 8'(i), 6'h00);
    preload(8'h3F, 6'h05);

    // Lookup vectors.
    for (int i = 0; i < 7; i++) begin
      tick;
      req_valid = lv[i].rv; req_pc = lv[i].pc;
      #1;
      chk("lk_tbl_en", tbl_en, lv[i].rv);
      chk("lk_tbl_we", tbl_we, 0);
      if (lv[i].rv) chk("lk_tbl_addr", tbl_addr, lv[i].exp_addr);
      tick;
      req_valid = 1'b0;
      #1;
      chk("lk_pred_valid", pred_valid, lv[i].rv);
      if (lv[i].rv) chk("lk_pred_taken", pred_taken, lv[i].exp_taken);
      $display("[TB] lookup pc=%0h addr=%0h pred_valid=%0b taken=%0b",
               lv[i].pc, tbl_addr, pred_valid, pred_taken);
    end

    // Training vectors, no competing lookups.
    for (int i = 0; i < 9; i++) begin
      tick;
      fb_valid = 1'b1; fb_pc = tv[i].pc;
      fb_mispredict = tv[i].mis; fb_outcome = tv[i].outc;
      #1;
      chk("tr_fb_ready", fb_ready, 1);
      tick;
      fb_valid = 1'b0;
      #1;
      chk("tr_rd_en", tbl_en, 1);
      chk("tr_rd_we", tbl_we, 0);
      chk("tr_rd_addr", tbl_addr, tv[i].exp_idx);
      tick; #1;
      chk("tr_rdstate_idle_port", tbl_en, 0);
      tick; #1;
      if (tv[i].exp_write) begin
        chk("tr_wr_we", tbl_we, 1);
        chk("tr_wr_addr", tbl_addr, tv[i].exp_idx);
        chk("tr_wr_data", tbl_wdata, tv[i].exp_val);
      end else begin
        chk("tr_nowrite_en", tbl_en, 0);
      end
      tick; #1;
      chk("tr_done_en", tbl_en, 0);
      $display("[TB] train idx=%0h mis=%0b out=%0b old=%0h mem_now=%0h",
               tv[i].exp_idx, tv[i].mis, tv[i].outc, tv[i].old, mem[tv[i].exp_idx]);
    end

    // Starvation: continuous lookups with one pending feedback.
    tick;
    req_valid = 1'b1; req_pc = 32'h40;
    fb_valid = 1'b1; fb_pc = 32'h80; fb_mispredict = 1'b1; fb_outcome = 1'b1;
    #1;
    chk("st_push_stall", req_stall, 0);
    tick;
    fb_valid = 1'b0;
    #1;
    for (int k = 1; k <= 7; k++) begin
      chk("st_blocked_stall", req_stall, 0);
      chk("st_blocked_addr", tbl_addr, 8'h10);
      tick;
    end
    chk("st_forced_stall", req_stall, 1);
    chk("st_forced_we", tbl_we, 0);
    chk("st_forced_addr", tbl_addr, 8'h20);
    tick;
    chk("st_rd_stall", req_stall, 0);
    chk("st_rd_lookup_addr", tbl_addr, 8'h10);
    tick;
    n = 0;
    while (!tbl_we && n < 20) begin
      n++;
      tick;
    end
    chk("st_wr_forced_after", n, 7);
    chk("st_wr_stall", req_stall, 1);
    chk("st_wr_data", tbl_wdata, 6'h01);
    $display("[TB] starvation write after %0d lookup cycles", n);
    tick;
    req_valid = 1'b0;
    tick; tick;

    // Overflow: five feedbacks back-to-back under continuous lookups.
    req_valid = 1'b1; req_pc = 32'h40;
    for (int k = 0; k < 5; k++) begin
      tick;
      fb_valid = 1'b1; fb_pc = 32'hC0 + 32'(4 * k);
      fb_mispredict = 1'b1; fb_outcome = 1'b1;
      #1;
      chk("ov_fb_ready", fb_ready, (k < 4) ? 1 : 0);
      $display("[TB] feedback %0d fb_ready=%0b", k, fb_ready);
    end
    tick;
    fb_valid = 1'b0;
    #1;
    chk("ov_drop_count", drop_count, 1);
    req_valid = 1'b0;
    for (int k = 0; k < 30; k++) tick;
    chk("ov_drained_en", tbl_en, 0);
    chk("ov_drained_ready", fb_ready, 1);
    for (int k = 0; k < 4; k++) chk("ov_mem_updated", mem[8'h30 + 8'(k)], 6'h01);
    chk("ov_mem_dropped", mem[8'h34], 6'h00);

    // Reset during WR abandons the write.
    tick;
    fb_valid = 1'b1; fb_pc = 32'hFC; fb_mispredict = 1'b1; fb_outcome = 1'b1;
    tick;
    fb_valid = 1'b0;
    tick;
    tick;
    chk("rw_in_wr_we", tbl_we, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_rst_we", tbl_we, 0);
    chk("rw_rst_en", tbl_en, 0);
    tick;
    chk("rw_rst_drop", drop_count, 0);
    rst_n = 1'b1;
    tick;
    chk("rw_fb_ready", fb_ready, 1);
    chk("rw_idle_en", tbl_en, 0);
    tick;
    chk("rw_empty_en", tbl_en, 0);
    chk("rw_mem_kept", mem[8'h3F], 6'h05);
    $display("[TB] reset during WR: mem[3F]=%0h", mem[8'h3F]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
